// File: rtl/eo_key_pkg.sv
// rtl/eo_key_pkg.sv - shared constants, types and helpers for the organ keyboard UI controller
//
// Purpose : PS/2 set-2 scan-code constants, ui_state encoding, a width helper,
//           and (with EO_ASCII_MAP_EN defined) the scan-code to ASCII map.
// Ports   : none (package)
// Macro   : EO_ASCII_MAP_EN enables ascii_map()
package eo_key_pkg;

    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    // Extended (E0-prefixed) arrow codes
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    typedef enum logic [1:0] {
        UI_WELCOME = 2'd0,
        UI_MENU    = 2'd1,
        UI_SONGSEL = 2'd2,
        UI_ACTIVE  = 2'd3
    } ui_state_t;

    // Index width for n items, never below one bit
    function automatic int w_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

`ifdef EO_ASCII_MAP_EN
    // Returns {valid, ascii}; letters come out uppercase
    function automatic logic [8:0] ascii_map(input logic [7:0] sc);
        case (sc)
            8'h1C: return {1'b1, 8'h41}; 8'h32: return {1'b1, 8'h42};
            8'h21: return {1'b1, 8'h43}; 8'h23: return {1'b1, 8'h44};
            8'h24: return {1'b1, 8'h45}; 8'h2B: return {1'b1, 8'h46};
            8'h34: return {1'b1, 8'h47}; 8'h33: return {1'b1, 8'h48};
            8'h43: return {1'b1, 8'h49}; 8'h3B: return {1'b1, 8'h4A};
            8'h42: return {1'b1, 8'h4B}; 8'h4B: return {1'b1, 8'h4C};
            8'h3A: return {1'b1, 8'h4D}; 8'h31: return {1'b1, 8'h4E};
            8'h44: return {1'b1, 8'h4F}; 8'h4D: return {1'b1, 8'h50};
            8'h15: return {1'b1, 8'h51}; 8'h2D: return {1'b1, 8'h52};
            8'h1B: return {1'b1, 8'h53}; 8'h2C: return {1'b1, 8'h54};
            8'h3C: return {1'b1, 8'h55}; 8'h2A: return {1'b1, 8'h56};
            8'h1D: return {1'b1, 8'h57}; 8'h22: return {1'b1, 8'h58};
            8'h35: return {1'b1, 8'h59}; 8'h1A: return {1'b1, 8'h5A};
            8'h45: return {1'b1, 8'h30}; 8'h16: return {1'b1, 8'h31};
            8'h1E: return {1'b1, 8'h32}; 8'h26: return {1'b1, 8'h33};
            8'h25: return {1'b1, 8'h34}; 8'h2E: return {1'b1, 8'h35};
            8'h36: return {1'b1, 8'h36}; 8'h3D: return {1'b1, 8'h37};
            8'h3E: return {1'b1, 8'h38}; 8'h46: return {1'b1, 8'h39};
            8'h29: return {1'b1, 8'h20};
            default: return 9'h000;
        endcase
    endfunction
`endif

endpackage

// File: rtl/eo_key_nav_ctrl_if.sv
// rtl/eo_key_nav_ctrl_if.sv - scan-code byte stream from the PS/2 decoder
//
// Purpose : carries one scan-code byte per key_valid strobe
// Signals : key_code[7:0] scan-code byte, key_valid one-cycle strobe
// Modports: master (decoder side, drives), slave (controller side, receives)
interface eo_key_nav_ctrl_if;
    logic [7:0] key_code;
    logic       key_valid;

    modport master (output key_code, output key_valid);
    modport slave  (input  key_code, input  key_valid);
endinterface

// File: rtl/eo_key_filter.sv
// rtl/eo_key_filter.sv - PS/2 prefix decode and make-code repeat suppression
//
// Purpose : strips F0/E0 prefixes, drops breaks, and suppresses an identical
//           make seen again within REPEAT_HOLD ticks of sys_clk/TICK_DIV.
// Ports   : sys_clk, rst_n (sync, active-low), key_code/key_valid in;
//           key_ok strobe with key_ext/key_byte, combinational in the
//           key_valid cycle of the final byte.
module eo_key_filter
    import eo_key_pkg::*;
#(
    parameter int TICK_DIV    = 128,
    parameter int REPEAT_HOLD = 10000
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic [7:0] key_code,
    input  logic       key_valid,
    output logic       key_ok,
    output logic       key_ext,
    output logic [7:0] key_byte
);
    localparam int DW = w_of(TICK_DIV);
    localparam int TW = $clog2(REPEAT_HOLD) + 1;

    logic [DW-1:0] div_cnt;
    logic [TW-1:0] tick;
    logic [TW-1:0] last_tick;
    logic [8:0]    last_key;
    logic          held;
    logic          brk;
    logic          ext;
    logic          is_prefix;
    logic          same_key;
    logic          in_hold;

    always_comb begin
        is_prefix = (key_code == SC_BRK) || (key_code == SC_EXT);
        same_key  = held && (last_key == {ext, key_code});
        // Unsigned TW-bit difference stays correct across tick wrap
        in_hold   = (tick - last_tick) < TW'(REPEAT_HOLD);
        key_ok    = key_valid && !is_prefix && !brk && !(same_key && in_hold);
        key_ext   = ext;
        key_byte  = key_code;
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            tick      <= '0;
            last_tick <= '0;
            last_key  <= '0;
            held      <= 1'b0;
            brk       <= 1'b0;
            ext       <= 1'b0;
        end else begin
            if (div_cnt == DW'(TICK_DIV - 1)) begin
                div_cnt <= '0;
                tick    <= tick + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (key_valid) begin
                if (key_code == SC_BRK) begin
                    brk <= 1'b1;
                end else if (key_code == SC_EXT) begin
                    ext <= 1'b1;
                end else begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                    if (brk) begin
                        // Releasing the held key re-arms it immediately
                        if (same_key) held <= 1'b0;
                    end else if (key_ok) begin
                        held      <= 1'b1;
                        last_key  <= {ext, key_code};
                        last_tick <= tick;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/eo_key_nav_ctrl.sv
// rtl/eo_key_nav_ctrl.sv - keyboard-driven UI controller for the electronic organ
//
// Purpose : username entry (WELCOME), ROWS x COLS main menu (MENU), paged song
//           selector (SONGSEL) and ACTIVE mode hand-off, driven by filtered keys.
// Ports   : sys_clk, rst_n (sync, active-low); key_if (slave: key_code,
//           key_valid); ui_state, mode, cursor_row, cursor_col, song_idx,
//           name_buf, name_len, key_evt pulse, overflow pulse.
// Macro   : EO_ASCII_MAP_EN stores ASCII instead of raw scan codes in name_buf
module eo_key_nav_ctrl
    import eo_key_pkg::*;
#(
    parameter int MAX_LEN     = 16,
    parameter int GRID_ROWS   = 2,
    parameter int GRID_COLS   = 2,
    parameter int PAGES       = 2,
    parameter int PAGE_ITEMS  = 4,
    parameter int TICK_DIV    = 128,
    parameter int REPEAT_HOLD = 10000
) (
    input  logic                                    sys_clk,
    input  logic                                    rst_n,
    eo_key_nav_ctrl_if.slave                        key_if,
    output logic [1:0]                              ui_state,
    output logic [3:0]                              mode,
    output logic [w_of(GRID_ROWS)-1:0]              cursor_row,
    output logic [w_of(GRID_COLS)-1:0]              cursor_col,
    output logic [w_of(PAGES*PAGE_ITEMS)-1:0]       song_idx,
    output logic [8*MAX_LEN-1:0]                    name_buf,
    output logic [$clog2(MAX_LEN+1)-1:0]            name_len,
    output logic                                    key_evt,
    output logic                                    overflow
);
    localparam int RW = w_of(GRID_ROWS);
    localparam int CW = w_of(GRID_COLS);
    localparam int PW = w_of(PAGES);
    localparam int IW = w_of(PAGE_ITEMS);
    localparam int SW = w_of(PAGES * PAGE_ITEMS);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic       key_ok;
    logic       key_ext;
    logic [7:0] key_byte;

    eo_key_filter #(
        .TICK_DIV    (TICK_DIV),
        .REPEAT_HOLD (REPEAT_HOLD)
    ) u_filter (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .key_code  (key_if.key_code),
        .key_valid (key_if.key_valid),
        .key_ok    (key_ok),
        .key_ext   (key_ext),
        .key_byte  (key_byte)
    );

    ui_state_t           st, st_n;
    logic [3:0]          mode_n;
    logic [RW-1:0]       row_n;
    logic [CW-1:0]       col_n;
    logic [PW-1:0]       page, page_n;
    logic [IW-1:0]       item, item_n;
    logic [8*MAX_LEN-1:0] buf_n;
    logic [LW-1:0]       len_n;
    logic                evt_n;
    logic                ovf_n;
    logic [7:0]          ch;
    logic                ch_ok;
    logic [3:0]          sel;
`ifdef EO_ASCII_MAP_EN
    logic [8:0]          amap;
`endif

    assign ui_state = st;
    assign song_idx = SW'(page) * SW'(PAGE_ITEMS) + SW'(item);

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            st         <= UI_WELCOME;
            mode       <= '0;
            cursor_row <= '0;
            cursor_col <= '0;
            page       <= '0;
            item       <= '0;
            name_buf   <= '0;
            name_len   <= '0;
            key_evt    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            st         <= st_n;
            mode       <= mode_n;
            cursor_row <= row_n;
            cursor_col <= col_n;
            page       <= page_n;
            item       <= item_n;
            name_buf   <= buf_n;
            name_len   <= len_n;
            key_evt    <= evt_n;
            overflow   <= ovf_n;
        end
    end

    always_comb begin
        st_n   = st;
        mode_n = mode;
        row_n  = cursor_row;
        col_n  = cursor_col;
        page_n = page;
        item_n = item;
        buf_n  = name_buf;
        len_n  = name_len;
        evt_n  = 1'b0;
        ovf_n  = 1'b0;
        sel    = 4'(int'(cursor_row) * GRID_COLS + int'(cursor_col));
`ifdef EO_ASCII_MAP_EN
        amap   = ascii_map(key_byte);
        ch_ok  = amap[8];
        ch     = amap[7:0];
`else
        ch_ok  = 1'b1;
        ch     = key_byte;
`endif

        if (key_ok) begin
            evt_n = 1'b1;
            case (st)
                UI_WELCOME: begin
                    if (!key_ext) begin
                        if (key_byte == SC_ENTER) begin
                            st_n  = UI_MENU;
                            row_n = '0;
                            col_n = '0;
                        end else if (key_byte == SC_ESC) begin
                            buf_n = '0;
                            len_n = '0;
                        end else if (key_byte == SC_BKSP) begin
                            if (name_len != '0) begin
                                buf_n[(int'(name_len) - 1) * 8 +: 8] = 8'h00;
                                len_n = name_len - 1'b1;
                            end
                        end else if (ch_ok) begin
                            if (name_len < LW'(MAX_LEN)) begin
                                buf_n[int'(name_len) * 8 +: 8] = ch;
                                len_n = name_len + 1'b1;
                            end else begin
                                ovf_n = 1'b1;
                            end
                        end
                    end
                end
                UI_MENU: begin
                    if (key_ext) begin
                        case (key_byte)
                            SC_UP:    row_n = (cursor_row == '0) ? RW'(GRID_ROWS - 1) : cursor_row - 1'b1;
                            SC_DOWN:  row_n = (cursor_row == RW'(GRID_ROWS - 1)) ? '0 : cursor_row + 1'b1;
                            SC_LEFT:  col_n = (cursor_col == '0) ? CW'(GRID_COLS - 1) : cursor_col - 1'b1;
                            SC_RIGHT: col_n = (cursor_col == CW'(GRID_COLS - 1)) ? '0 : cursor_col + 1'b1;
                            default: ;
                        endcase
                    end else if (key_byte == SC_ENTER) begin
                        mode_n = sel;
                        // Grid item 0 is the song player, which needs a song first
                        if (sel == 4'd0) begin
                            st_n   = UI_SONGSEL;
                            page_n = '0;
                            item_n = '0;
                        end else begin
                            st_n = UI_ACTIVE;
                        end
                    end else if (key_byte == SC_ESC) begin
                        st_n = UI_WELCOME;
                    end
                end
                UI_SONGSEL: begin
                    if (key_ext) begin
                        case (key_byte)
                            SC_UP:    item_n = (item == '0) ? IW'(PAGE_ITEMS - 1) : item - 1'b1;
                            SC_DOWN:  item_n = (item == IW'(PAGE_ITEMS - 1)) ? '0 : item + 1'b1;
                            SC_LEFT: begin
                                page_n = (page == '0) ? PW'(PAGES - 1) : page - 1'b1;
                                item_n = '0;
                            end
                            SC_RIGHT: begin
                                page_n = (page == PW'(PAGES - 1)) ? '0 : page + 1'b1;
                                item_n = '0;
                            end
                            default: ;
                        endcase
                    end else if (key_byte == SC_ENTER) begin
                        st_n = UI_ACTIVE;
                    end else if (key_byte == SC_ESC) begin
                        st_n = UI_MENU;
                    end
                end
                UI_ACTIVE: begin
                    if (!key_ext && key_byte == SC_ESC) st_n = UI_MENU;
                end
                default: st_n = UI_WELCOME;
            endcase
        end
    end
endmodule

// File: tb/tb_eo_key_nav_ctrl.sv
// tb/tb_eo_key_nav_ctrl.sv - scoreboard bench for eo_key_nav_ctrl
module tb_eo_key_nav_ctrl;

    localparam int MAX_LEN     = 16;
    localparam int ROWS        = 2;
    localparam int COLS        = 2;
    localparam int PAGES       = 2;
    localparam int ITEMS       = 4;
    localparam int TICK_DIV    = 2;
    localparam int REPEAT_HOLD = 200;

    logic         sys_clk = 1'b0;
    logic         rst_n;
    logic [1:0]   ui_state;
    logic [3:0]   mode;
    logic [0:0]   cursor_row;
    logic [0:0]   cursor_col;
    logic [2:0]   song_idx;
    logic [127:0] name_buf;
    logic [4:0]   name_len;
    logic         key_evt;
    logic         overflow;

    always #5 sys_clk = ~sys_clk;

    eo_key_nav_ctrl_if kif ();

    eo_key_nav_ctrl #(
        .MAX_LEN(MAX_LEN), .GRID_ROWS(ROWS), .GRID_COLS(COLS), .PAGES(PAGES),
        .PAGE_ITEMS(ITEMS), .TICK_DIV(TICK_DIV), .REPEAT_HOLD(REPEAT_HOLD)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .key_if(kif),
        .ui_state(ui_state), .mode(mode), .cursor_row(cursor_row),
        .cursor_col(cursor_col), .song_idx(song_idx), .name_buf(name_buf),
        .name_len(name_len), .key_evt(key_evt), .overflow(overflow)
    );

    typedef struct {
        logic [1:0]   st;
        logic [3:0]   mode;
        logic [0:0]   row;
        logic [0:0]   col;
        logic [2:0]   song;
        logic [127:0] nbuf;
        logic [4:0]   len;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   evt_cnt = 0;

    int           m_st, m_mode, m_row, m_col, m_page, m_item, m_len;
    logic [127:0] m_buf;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_mode = 0; m_row = 0; m_col = 0;
        m_page = 0; m_item = 0; m_len = 0; m_buf = '0;
    endtask

    // Reference behaviour of one accepted make key
    task automatic model(input bit ext, input logic [7:0] c, output bit ovf);
        ovf = 1'b0;
        case (m_st)
            0: if (!ext) begin
                if (c == 8'h5A) begin m_st = 1; m_row = 0; m_col = 0; end
                else if (c == 8'h76) begin m_buf = '0; m_len = 0; end
                else if (c == 8'h66) begin
                    if (m_len > 0) begin m_len--; m_buf[m_len*8 +: 8] = 8'h00; end
                end
                else if (m_len < MAX_LEN) begin m_buf[m_len*8 +: 8] = c; m_len++; end
                else ovf = 1'b1;
            end
            1: if (ext) begin
                if (c == 8'h75) m_row = (m_row + ROWS - 1) % ROWS;
                if (c == 8'h72) m_row = (m_row + 1) % ROWS;
                if (c == 8'h6B) m_col = (m_col + COLS - 1) % COLS;
                if (c == 8'h74) m_col = (m_col + 1) % COLS;
            end else if (c == 8'h5A) begin
                m_mode = m_row * COLS + m_col;
                if (m_mode == 0) begin m_st = 2; m_page = 0; m_item = 0; end
                else m_st = 3;
            end else if (c == 8'h76) m_st = 0;
            2: if (ext) begin
                if (c == 8'h75) m_item = (m_item + ITEMS - 1) % ITEMS;
                if (c == 8'h72) m_item = (m_item + 1) % ITEMS;
                if (c == 8'h6B) begin m_page = (m_page + PAGES - 1) % PAGES; m_item = 0; end
                if (c == 8'h74) begin m_page = (m_page + 1) % PAGES; m_item = 0; end
            end else if (c == 8'h5A) m_st = 3;
            else if (c == 8'h76) m_st = 1;
            default: if (!ext && c == 8'h76) m_st = 1;
        endcase
    endtask

    task automatic push_exp(input bit ovf);
        exp_t e;
        e.st   = 2'(m_st);
        e.mode = 4'(m_mode);
        e.row  = 1'(m_row);
        e.col  = 1'(m_col);
        e.song = 3'(m_page * ITEMS + m_item);
        e.nbuf = m_buf;
        e.len  = 5'(m_len);
        e.ovf  = ovf;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge sys_clk);
        kif.key_code  = b;
        kif.key_valid = 1'b1;
        @(negedge sys_clk);
        kif.key_valid = 1'b0;
    endtask

    task automatic make(input bit ext, input logic [7:0] c, input bit acc);
        bit ovf;
        if (acc) begin
            model(ext, c, ovf);
            push_exp(ovf);
        end
        if (ext) send(8'hE0);
        send(c);
    endtask

    task automatic brk(input bit ext, input logic [7:0] c);
        if (ext) send(8'hE0);
        send(8'hF0);
        send(c);
    endtask

    task automatic press(input bit ext, input logic [7:0] c);
        make(ext, c, 1'b1);
        brk(ext, c);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_state"},  128'(ui_state),   128'(0));
        chk({tag, "_mode"},   128'(mode),       128'(0));
        chk({tag, "_row"},    128'(cursor_row), 128'(0));
        chk({tag, "_col"},    128'(cursor_col), 128'(0));
        chk({tag, "_song"},   128'(song_idx),   128'(0));
        chk({tag, "_buf"},    name_buf,         128'(0));
        chk({tag, "_len"},    128'(name_len),   128'(0));
        chk({tag, "_evt"},    128'(key_evt),    128'(0));
        chk({tag, "_ovf"},    128'(overflow),   128'(0));
    endtask

    always @(negedge sys_clk) begin
        if (rst_n && key_evt) begin
            evt_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_evt", 128'(1), 128'(0));
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_state", 128'(ui_state),   128'(mon_e.st));
                chk("sb_mode",  128'(mode),       128'(mon_e.mode));
                chk("sb_row",   128'(cursor_row), 128'(mon_e.row));
                chk("sb_col",   128'(cursor_col), 128'(mon_e.col));
                chk("sb_song",  128'(song_idx),   128'(mon_e.song));
                chk("sb_buf",   name_buf,         mon_e.nbuf);
                chk("sb_len",   128'(name_len),   128'(mon_e.len));
                chk("sb_ovf",   128'(overflow),   128'(mon_e.ovf));
            end
        end else if (rst_n && overflow) begin
            chk("stray_overflow", 128'(1), 128'(0));
        end
    end

    logic [7:0] chars [17] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44,
                               8'h4D, 8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B};

    initial begin
        int evt0;
        kif.key_code  = 8'h00;
        kif.key_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
        chk_reset("rst");

        // Name entry with a break in between, then ENTER
        press(0, 8'h1C);
        press(0, 8'h32);
        press(0, 8'h5A);
        chk("t1_len",   128'(name_len),       128'(2));
        chk("t1_buf",   128'(name_buf[15:0]), 128'(16'h321C));
        chk("t1_state", 128'(ui_state),       128'(1));
        press(0, 8'h76);
        chk("esc_keeps_name", 128'(name_len), 128'(2));
        press(0, 8'h76);
        chk("esc_clears", 128'(name_len), 128'(0));
        press(1, 8'h75);

        // Fill past MAX_LEN, then erase past empty
        for (int i = 0; i < 17; i++) press(0, chars[i]);
        chk("full_len", 128'(name_len), 128'(16));
        for (int i = 0; i < 17; i++) press(0, 8'h66);
        chk("bksp_len", 128'(name_len), 128'(0));
        chk("bksp_buf", name_buf,       128'(0));

        // Repeat suppression
        evt0 = evt_cnt;
        make(0, 8'h1C, 1'b1);
        make(0, 8'h1C, 1'b0);
        repeat (20) @(negedge sys_clk);
        brk(0, 8'h1C);
        make(0, 8'h1C, 1'b1);
        repeat (REPEAT_HOLD * TICK_DIV + 10) @(negedge sys_clk);
        make(0, 8'h1C, 1'b1);
        brk(0, 8'h1C);
        repeat (4) @(negedge sys_clk);
        chk("repeat_evts", 128'(evt_cnt - evt0), 128'(3));

        // Menu grid
        press(0, 8'h5A);
        press(1, 8'h75);
        chk("menu_up_wrap", 128'(cursor_row), 128'(1));
        press(1, 8'h74);
        press(1, 8'h74);
        chk("menu_right_wrap", 128'(cursor_col), 128'(0));
        press(1, 8'h74);
        press(0, 8'h5A);
        chk("menu_mode3", 128'(mode),     128'(3));
        chk("menu_active", 128'(ui_state), 128'(3));
        press(1, 8'h75);
        press(0, 8'h76);
        chk("active_esc", 128'(ui_state), 128'(1));
        press(1, 8'h72);
        press(1, 8'h6B);
        press(0, 8'h5A);
        chk("songsel_enter", 128'(ui_state), 128'(2));

        // Song selector
        for (int i = 0; i < 5; i++) press(1, 8'h72);
        chk("song_down5", 128'(song_idx), 128'(1));
        press(1, 8'h74);
        chk("song_right", 128'(song_idx), 128'(4));
        press(1, 8'h6B);
        chk("song_left", 128'(song_idx), 128'(0));
        press(1, 8'h75);
        press(0, 8'h76);
        chk("songsel_esc", 128'(ui_state), 128'(1));
        press(1, 8'h72);

        // Reset right after an E0 prefix, with a byte arriving in the reset cycle
        send(8'hE0);
        @(negedge sys_clk);
        kif.key_code  = 8'h75;
        kif.key_valid = 1'b1;
        rst_n = 1'b0;
        @(negedge sys_clk);
        kif.key_valid = 1'b0;
        rst_n = 1'b1;
        chk_reset("midrst");
        model_reset();
        press(0, 8'h75);
        chk("post_rst_len", 128'(name_len),      128'(1));
        chk("post_rst_buf", 128'(name_buf[7:0]), 128'(8'h75));

        repeat (4) @(negedge sys_clk);
        chk("sb_drained", 128'(exp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
